// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-port architectural register file with ROB-tag scoreboard
//
// Holds 32 architectural registers. Each register has an XLEN-bit value, the
// ROB tag of its youngest in-flight producer, and a ready bit. The rename stage
// marks destinations pending (tag + ready=0). The commit stage writes
// architectural data and clears the pending state when the committing tag is
// still the youngest producer. A mispredict flush marks every register ready
// again; tags are left as they are.
//
// Parameters:
//   XLEN       data width
//   ROB_ID_W   ROB tag width
//   DEC_PORTS  rename ports per cycle (index 0 oldest)
//   CMT_PORTS  commit ports per cycle (index 0 oldest)
//   RD_PORTS   rs1/rs2 read pairs per cycle
//
// Ports:
//   clk                      in   clock, state updates on posedge
//   rst_n                    in   asynchronous active-low reset
//   flush                    in   mispredict: drop renames, set all ready
//   dec_valid/rd/rob_id      in   rename requests (flattened per port)
//   cmt_valid/rd/rob_id/data in   commits (flattened per port)
//   rs1_addr, rs2_addr       in   source addresses (flattened per port)
//   rs1_data, rs2_data       out  source values
//   rs1_tag, rs2_tag         out  pending producer tag
//   rs1_ready, rs2_ready     out  1 = data valid, 0 = wait on tag
//
// Build option:
//   REGFILE_CMT_BYPASS_EN    when defined, reads forward same-cycle commit data
//                            whose tag matches the stored producer tag.
//                            When undefined, committed values appear on the
//                            cycle after the commit edge.
//
// Reads are combinational from registered state (plus optional bypass);
// renames performed on the current edge are not visible to reads.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int ROB_ID_W  = 4,
    parameter int DEC_PORTS = 2,
    parameter int CMT_PORTS = 2,
    parameter int RD_PORTS  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [DEC_PORTS-1:0]          dec_valid,
    input  logic [DEC_PORTS*5-1:0]        dec_rd,
    input  logic [DEC_PORTS*ROB_ID_W-1:0] dec_rob_id,
    input  logic [CMT_PORTS-1:0]          cmt_valid,
    input  logic [CMT_PORTS*5-1:0]        cmt_rd,
    input  logic [CMT_PORTS*ROB_ID_W-1:0] cmt_rob_id,
    input  logic [CMT_PORTS*XLEN-1:0]     cmt_data,
    input  logic [RD_PORTS*5-1:0]         rs1_addr,
    input  logic [RD_PORTS*5-1:0]         rs2_addr,
    output logic [RD_PORTS*XLEN-1:0]      rs1_data,
    output logic [RD_PORTS*XLEN-1:0]      rs2_data,
    output logic [RD_PORTS*ROB_ID_W-1:0]  rs1_tag,
    output logic [RD_PORTS*ROB_ID_W-1:0]  rs2_tag,
    output logic [RD_PORTS-1:0]           rs1_ready,
    output logic [RD_PORTS-1:0]           rs2_ready
);

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [XLEN-1:0]     data;
        logic [ROB_ID_W-1:0] tag;
        logic                ready;
    } rd_res_t;

    // Architectural state
    logic [XLEN-1:0]     data_r  [NUM_REGS];
    logic [ROB_ID_W-1:0] tag_r   [NUM_REGS];
    logic [NUM_REGS-1:0] ready_r;

    // Next-state and per-register decode of this cycle's ports
    logic [XLEN-1:0]     data_nxt_s  [NUM_REGS];
    logic [ROB_ID_W-1:0] tag_nxt_s   [NUM_REGS];
    logic [NUM_REGS-1:0] ready_nxt_s;
    logic [XLEN:0]       cmt_win_s   [NUM_REGS];   // {hit, data} of winning commit
    logic [ROB_ID_W:0]   dec_win_s   [NUM_REGS];   // {hit, tag} of winning rename
    logic [NUM_REGS-1:0] tag_hit_s;                // a commit carries the stored tag

    // Winning commit (highest valid port) targeting rd; rd 0 never matches.
    function automatic logic [XLEN:0] cmt_pick(input logic [REG_AW-1:0] rd);
        logic [XLEN:0] res;
        res = {(XLEN+1){1'b0}};
        for (int c = 0; c < CMT_PORTS; c++) begin
            res = (cmt_valid[c] && (rd != 5'd0) && (cmt_rd[c*REG_AW +: REG_AW] == rd))
                ? {1'b1, cmt_data[c*XLEN +: XLEN]} : res;
        end
        return res;
    endfunction

    // Winning rename (highest valid port) targeting rd; suppressed by flush.
    function automatic logic [ROB_ID_W:0] dec_pick(input logic [REG_AW-1:0] rd);
        logic [ROB_ID_W:0] res;
        res = {(ROB_ID_W+1){1'b0}};
        for (int d = 0; d < DEC_PORTS; d++) begin
            res = (!flush && dec_valid[d] && (rd != 5'd0) &&
                   (dec_rd[d*REG_AW +: REG_AW] == rd))
                ? {1'b1, dec_rob_id[d*ROB_ID_W +: ROB_ID_W]} : res;
        end
        return res;
    endfunction

    // True when any valid commit to rd carries the given (stored) tag.
    function automatic logic cmt_tag_match(input logic [REG_AW-1:0]   rd,
                                           input logic [ROB_ID_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CMT_PORTS; c++) begin
            hit = hit | (cmt_valid[c] && (rd != 5'd0) &&
                         (cmt_rd[c*REG_AW +: REG_AW] == rd) &&
                         (cmt_rob_id[c*ROB_ID_W +: ROB_ID_W] == tag));
        end
        return hit;
    endfunction

`ifdef REGFILE_CMT_BYPASS_EN
    // Highest-index commit to rd whose tag matches the stored producer tag.
    function automatic logic [XLEN:0] cmt_fwd(input logic [REG_AW-1:0]   rd,
                                              input logic [ROB_ID_W-1:0] tag);
        logic [XLEN:0] res;
        res = {(XLEN+1){1'b0}};
        for (int c = 0; c < CMT_PORTS; c++) begin
            res = (cmt_valid[c] && (rd != 5'd0) &&
                   (cmt_rd[c*REG_AW +: REG_AW] == rd) &&
                   (cmt_rob_id[c*ROB_ID_W +: ROB_ID_W] == tag))
                ? {1'b1, cmt_data[c*XLEN +: XLEN]} : res;
        end
        return res;
    endfunction
`endif

    // Source lookup: x0 is hard-wired, otherwise registered state (plus bypass).
    function automatic rd_res_t lookup(input logic [REG_AW-1:0] addr);
        rd_res_t res;
`ifdef REGFILE_CMT_BYPASS_EN
        logic [XLEN:0] fwd;
`endif
        if (addr == 5'd0) begin
            res.data  = {XLEN{1'b0}};
            res.tag   = {ROB_ID_W{1'b0}};
            res.ready = 1'b1;
        end else begin
            res.data  = data_r[addr];
            res.tag   = tag_r[addr];
            res.ready = ready_r[addr];
`ifdef REGFILE_CMT_BYPASS_EN
            fwd       = cmt_fwd(addr, tag_r[addr]);
            res.data  = fwd[XLEN] ? fwd[XLEN-1:0] : res.data;
            res.tag   = fwd[XLEN] ? {ROB_ID_W{1'b0}} : res.tag;
            res.ready = fwd[XLEN] ? 1'b1 : res.ready;
`endif
        end
        return res;
    endfunction

    // Per-register decode of the commit and rename ports.
    always_comb begin
        tag_hit_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            cmt_win_s[i]  = cmt_pick(5'(i));
            dec_win_s[i]  = dec_pick(5'(i));
            tag_hit_s[i]  = cmt_tag_match(5'(i), tag_r[i]);
        end
    end

    // Next-state: commit writes data, rename overrides commit for ready,
    // flush forces every register ready. x0 stays at its reset value.
    always_comb begin
        ready_nxt_s = {NUM_REGS{1'b1}};
        for (int i = 0; i < NUM_REGS; i++) begin
            data_nxt_s[i] = data_r[i];
            tag_nxt_s[i]  = tag_r[i];
            if (i == 0) begin
                data_nxt_s[i]  = {XLEN{1'b0}};
                tag_nxt_s[i]   = {ROB_ID_W{1'b0}};
                ready_nxt_s[i] = 1'b1;
            end else begin
                data_nxt_s[i] = cmt_win_s[i][XLEN] ? cmt_win_s[i][XLEN-1:0] : data_r[i];
                tag_nxt_s[i]  = dec_win_s[i][ROB_ID_W] ? dec_win_s[i][ROB_ID_W-1:0]
                                                       : tag_r[i];
                if (flush) begin
                    ready_nxt_s[i] = 1'b1;
                end else if (dec_win_s[i][ROB_ID_W]) begin
                    ready_nxt_s[i] = 1'b0;
                end else if (tag_hit_s[i]) begin
                    ready_nxt_s[i] = 1'b1;
                end else begin
                    ready_nxt_s[i] = ready_r[i];
                end
            end
        end
    end

    // Architectural state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_r[i] <= {XLEN{1'b0}};
                tag_r[i]  <= {ROB_ID_W{1'b0}};
            end
            ready_r <= {NUM_REGS{1'b1}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_r[i] <= data_nxt_s[i];
                tag_r[i]  <= tag_nxt_s[i];
            end
            ready_r <= ready_nxt_s;
        end
    end

    // Combinational source reads for every read pair.
    always_comb begin
        rd_res_t r1;
        rd_res_t r2;
        rs1_data  = {(RD_PORTS*XLEN){1'b0}};
        rs2_data  = {(RD_PORTS*XLEN){1'b0}};
        rs1_tag   = {(RD_PORTS*ROB_ID_W){1'b0}};
        rs2_tag   = {(RD_PORTS*ROB_ID_W){1'b0}};
        rs1_ready = {RD_PORTS{1'b0}};
        rs2_ready = {RD_PORTS{1'b0}};
        for (int p = 0; p < RD_PORTS; p++) begin
            r1 = lookup(rs1_addr[p*REG_AW +: REG_AW]);
            r2 = lookup(rs2_addr[p*REG_AW +: REG_AW]);
            rs1_data[p*XLEN +: XLEN]         = r1.data;
            rs1_tag[p*ROB_ID_W +: ROB_ID_W]  = r1.tag;
            rs1_ready[p]                     = r1.ready;
            rs2_data[p*XLEN +: XLEN]         = r2.data;
            rs2_tag[p*ROB_ID_W +: ROB_ID_W]  = r2.tag;
            rs2_ready[p]                     = r2.ready;
        end
    end

endmodule
